// File: rtl/ws2812_axil_pattern_master.sv
// AXI4-Lite pattern master: writes N pattern words, reads them back and
// compares, reporting mismatches, bad responses and handshake timeouts.
module ws2812_axil_pattern_master #(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int          C_M_AXI_ADDR_WIDTH         = 32,
  parameter int          C_M_AXI_DATA_WIDTH         = 32,
  parameter int          C_M_TRANSACTIONS_NUM       = 4,
  parameter int          C_TIMEOUT_CYCLES           = 1024
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              INIT_AXI_TXN,
  input  logic [1:0]                        MODE,
  input  logic [31:0]                       SEED,
  output logic                              TXN_DONE,
  output logic                              ERROR,
  output logic                              TIMEOUT,
  output logic [15:0]                       ERR_COUNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     FAIL_ADDR,
  output logic                              BUSY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SH = $clog2(DW / 8);
  localparam int IW = 11;
  localparam logic [IW-1:0] LAST = IW'(C_M_TRANSACTIONS_NUM - 1);
  localparam logic [AW-1:0] BASE = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
  localparam logic [31:0]   TAPS = 32'h8020_0003;
  localparam logic [31:0]   TLIM = 32'(C_TIMEOUT_CYCLES);
  localparam logic          TEN  = (C_TIMEOUT_CYCLES != 0);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]    state;
  logic          init_q;
  logic [1:0]    mode_q;
  logic [31:0]   seed_q;
  logic [31:0]   lfsr;
  logic [31:0]   tcnt;
  logic [31:0]   pat;
  logic [IW-1:0] idx;
  logic          aw_done;
  logic          w_done;
  logic [DW-1:0] word;
  logic [AW-1:0] cur_addr;
  logic          start;
  logic          tmo;
  logic          step;
  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;
  logic          ar_hs;
  logic          r_hs;
  logic          wr_ok;
  logic          rd_bad;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  function automatic logic [31:0] lfsr_init(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;

  assign start    = INIT_AXI_TXN && !init_q && !BUSY;
  assign cur_addr = BASE + (AW'(idx) << SH);
  assign tmo      = TEN && (tcnt == TLIM);
  assign aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs     = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs     = M_AXI_BREADY && M_AXI_BVALID;
  assign ar_hs    = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs     = M_AXI_RREADY && M_AXI_RVALID;
  assign wr_ok    = (aw_done || aw_hs) && (w_done || w_hs);
  assign rd_bad   = (M_AXI_RDATA != word) || (M_AXI_RRESP != 2'b00);

  always_comb begin
    pat = 32'd0;
    unique case (mode_q)
      2'd0:    pat = seed_q + 32'(idx);
      2'd1:    pat = 32'd1 << idx[4:0];
      2'd2:    pat = lfsr;
      default: pat = ~(seed_q + 32'(idx));
    endcase
  end

  if (DW == 64) begin : g_w64
    assign word = {~pat, pat};
  end else begin : g_w32
    assign word = pat;
  end

  always_comb begin
    step = 1'b0;
    unique case (state)
      S_WR_ADDR: step = wr_ok;
      S_WR_RESP: step = b_hs;
      S_RD_ADDR: step = ar_hs;
      S_RD_DATA: step = r_hs;
      default:   step = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= S_IDLE;
      init_q        <= 1'b0;
      mode_q        <= 2'd0;
      seed_q        <= 32'd0;
      lfsr          <= 32'd0;
      tcnt          <= 32'd0;
      idx           <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      TXN_DONE      <= 1'b0;
      ERROR         <= 1'b0;
      TIMEOUT       <= 1'b0;
      ERR_COUNT     <= 16'd0;
      FAIL_ADDR     <= '0;
      BUSY          <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      init_q <= INIT_AXI_TXN;
      if (start) begin
        state     <= S_WR_ADDR;
        BUSY      <= 1'b1;
        TXN_DONE  <= 1'b0;
        ERROR     <= 1'b0;
        TIMEOUT   <= 1'b0;
        ERR_COUNT <= 16'd0;
        FAIL_ADDR <= '0;
        mode_q    <= MODE;
        seed_q    <= SEED;
        lfsr      <= lfsr_init(SEED);
        idx       <= '0;
        tcnt      <= 32'd0;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end else begin
        if (BUSY)
          tcnt <= tcnt + 32'd1;
        unique case (state)
          S_WR_ADDR: begin
            if (!aw_done && !M_AXI_AWVALID) begin
              M_AXI_AWVALID <= 1'b1;
              M_AXI_AWADDR  <= cur_addr;
            end
            if (!w_done && !M_AXI_WVALID) begin
              M_AXI_WVALID <= 1'b1;
              M_AXI_WDATA  <= word;
            end
            if (aw_hs) begin
              M_AXI_AWVALID <= 1'b0;
              aw_done       <= 1'b1;
            end
            if (w_hs) begin
              M_AXI_WVALID <= 1'b0;
              w_done       <= 1'b1;
            end
            if (wr_ok) begin
              state        <= S_WR_RESP;
              M_AXI_BREADY <= 1'b1;
              aw_done      <= 1'b0;
              w_done       <= 1'b0;
              tcnt         <= 32'd0;
            end
          end
          S_WR_RESP: begin
            if (b_hs) begin
              M_AXI_BREADY <= 1'b0;
              tcnt         <= 32'd0;
              if (M_AXI_BRESP != 2'b00) begin
                ERROR <= 1'b1;
                if (!ERROR)
                  FAIL_ADDR <= cur_addr;
              end
              // read phase replays the same sequence from the seed
              if (idx == LAST) begin
                idx   <= '0;
                lfsr  <= lfsr_init(seed_q);
                state <= S_RD_ADDR;
              end else begin
                idx   <= idx + 1'b1;
                lfsr  <= lfsr_step(lfsr);
                state <= S_WR_ADDR;
              end
            end
          end
          S_RD_ADDR: begin
            if (!M_AXI_ARVALID) begin
              M_AXI_ARVALID <= 1'b1;
              M_AXI_ARADDR  <= cur_addr;
            end
            if (ar_hs) begin
              M_AXI_ARVALID <= 1'b0;
              M_AXI_RREADY  <= 1'b1;
              state         <= S_RD_DATA;
              tcnt          <= 32'd0;
            end
          end
          S_RD_DATA: begin
            if (r_hs) begin
              M_AXI_RREADY <= 1'b0;
              tcnt         <= 32'd0;
              if (rd_bad) begin
                ERROR <= 1'b1;
                if (ERR_COUNT != 16'hFFFF)
                  ERR_COUNT <= ERR_COUNT + 16'd1;
                if (!ERROR)
                  FAIL_ADDR <= cur_addr;
              end
              if (idx == LAST) begin
                state    <= S_DONE;
                BUSY     <= 1'b0;
                TXN_DONE <= 1'b1;
              end else begin
                idx   <= idx + 1'b1;
                lfsr  <= lfsr_step(lfsr);
                state <= S_RD_ADDR;
              end
            end
          end
          default: ;
        endcase
        if (BUSY && !step && tmo) begin
          M_AXI_AWVALID <= 1'b0;
          M_AXI_WVALID  <= 1'b0;
          M_AXI_BREADY  <= 1'b0;
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY  <= 1'b0;
          ERROR         <= 1'b1;
          TIMEOUT       <= 1'b1;
          if (!ERROR)
            FAIL_ADDR <= cur_addr;
          BUSY          <= 1'b0;
          TXN_DONE      <= 1'b1;
          state         <= S_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ws2812_axil_pattern_master.sv
// Bench for ws2812_axil_pattern_master: memory slave with fault knobs,
// pattern reference model and randomized runs.
module tb_ws2812_axil_pattern_master;

  localparam int N = 40;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [31:0] seed = 32'd0;
  logic txn_done, error, timeout, busy;
  logic [15:0] err_count;
  logic [31:0] fail_addr;
  logic [31:0] awaddr, wdata, araddr;
  logic [31:0] rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready;
  logic [1:0] bresp, rresp;
  logic bvalid, bready, arvalid, arready, rvalid, rready;

  int n_tests = 0;
  int n_fail = 0;

  int corrupt_idx = -1;
  int slverr_idx = -1;
  bit aw_lag = 1'b0;
  bit aw_never = 1'b0;
  bit rnd = 1'b0;

  logic [31:0] mem [0:63];
  logic [31:0] aw_log [$];
  logic [31:0] ar_log [$];
  int nwr = 0;
  int nrd = 0;
  logic aw_got, w_got, ar_got;
  logic [31:0] aw_a, w_d, ar_a;
  int lag;

  always #5 clk = ~clk;

  ws2812_axil_pattern_master #(
    .C_M_TRANSACTIONS_NUM(N)
  ) u_dut (
    .ACLK(clk), .ARESETN(rst_n), .INIT_AXI_TXN(init),
    .MODE(mode), .SEED(seed),
    .TXN_DONE(txn_done), .ERROR(error), .TIMEOUT(timeout),
    .ERR_COUNT(err_count), .FAIL_ADDR(fail_addr), .BUSY(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2) & 63;
  endfunction

  function automatic bit coin();
    return !rnd || ($urandom_range(0, 3) != 0);
  endfunction

  // memory slave; all handshakes registered, fault knobs set by the stimulus
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      arready <= 1'b0; rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'd0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0; lag <= 0;
      aw_a <= 32'd0; w_d <= 32'd0; ar_a <= 32'd0;
    end else begin
      if (awvalid && awready) begin
        aw_got <= 1'b1; aw_a <= awaddr; awready <= 1'b0;
        aw_log.push_back(awaddr);
      end else if (awvalid && !aw_got && !aw_never)
        awready <= aw_lag ? (w_got && lag >= 1) : coin();
      if (wvalid && wready) begin
        w_got <= 1'b1; w_d <= wdata; wready <= 1'b0;
      end else if (wvalid && !w_got)
        wready <= coin();
      if (w_got && !aw_got)
        lag <= lag + 1;
      if (aw_got && w_got && !bvalid && coin()) begin
        mem[widx(aw_a)] <= w_d;
        nwr <= nwr + 1;
        bvalid <= 1'b1;
        bresp <= (widx(aw_a) == slverr_idx) ? 2'b10 : 2'b00;
        aw_got <= 1'b0; w_got <= 1'b0; lag <= 0;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        ar_got <= 1'b1; ar_a <= araddr; arready <= 1'b0;
        ar_log.push_back(araddr);
      end else if (arvalid && !ar_got)
        arready <= coin();
      if (ar_got && !rvalid && coin()) begin
        rvalid <= 1'b1;
        rdata <= mem[widx(ar_a)] ^
                 ((widx(ar_a) == corrupt_idx) ? 32'h0000_0100 : 32'd0);
        rresp <= 2'b00;
        ar_got <= 1'b0;
        nrd <= nrd + 1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  function automatic logic [31:0] pat_model(input logic [1:0] m,
                                            input logic [31:0] s,
                                            input int i);
    logic [31:0] v;
    case (m)
      2'd0: return s + 32'(i);
      2'd1: return 32'h1 << (i % 32);
      2'd2: begin
        v = (s == 32'd0) ? 32'd1 : s;
        for (int k = 0; k < i; k++)
          v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
        return v;
      end
      default: return ~(s + 32'(i));
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [1:0] m, input logic [31:0] s);
    mode = m; seed = s; init = 1'b1;
    @(negedge clk); init = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!txn_done && c < 20000) begin
      @(negedge clk); c++;
    end
    chk({tag, "_fin"}, txn_done, 1);
  endtask

  task automatic verify(input string tag, input logic [1:0] m,
                        input logic [31:0] s, input int wr0, input int rd0,
                        input int e_cnt, input bit e_err,
                        input logic [31:0] e_fa);
    wait_done(tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, error, e_err);
    chk({tag, "_cnt"}, err_count, e_cnt);
    chk({tag, "_tmo"}, timeout, 0);
    if (e_err) chk({tag, "_fa"}, fail_addr, e_fa);
    chk({tag, "_nwr"}, nwr - wr0, N);
    chk({tag, "_nrd"}, nrd - rd0, N);
    for (int i = 0; i < N; i++)
      chk({tag, "_word"}, mem[i], pat_model(m, s, i));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int wr0, rd0, al0, c, e_cnt;
    bit e_err;
    logic [1:0] m;
    logic [31:0] s, fa;

    repeat (3) @(negedge clk);
    chk("rst_ctl", {txn_done, error, timeout, busy, awvalid, wvalid,
                    bready, arvalid, rready}, 0);
    chk("rst_cnt", err_count, 0);
    chk("rst_fa", fail_addr, 0);
    chk("rst_bus", {awaddr, wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: incrementing pattern, always-ready slave
    wr0 = nwr; rd0 = nrd; al0 = aw_log.size();
    start(2'd0, 32'h10);
    verify("t1", 2'd0, 32'h10, wr0, rd0, 0, 0, 0);
    chk("t1_w3", mem[3], 32'h13);
    for (int i = 0; i < N; i++) begin
      chk("t1_awaddr", aw_log[al0 + i], BASE + 32'(4 * i));
      chk("t1_araddr", ar_log[rd0 + i], BASE + 32'(4 * i));
    end
    chk("t1_const", {awprot, arprot, wstrb}, 10'h00F);

    // 2: readback of word 2 corrupted
    corrupt_idx = 2;
    wr0 = nwr; rd0 = nrd;
    start(2'd0, 32'h10);
    verify("t2", 2'd0, 32'h10, wr0, rd0, 1, 1, 32'h4000_0008);
    corrupt_idx = -1;

    // 3: SLVERR on word 1, AWREADY trailing WREADY
    slverr_idx = 1; aw_lag = 1'b1;
    wr0 = nwr; rd0 = nrd;
    start(2'd3, 32'hA5A5_0000);
    verify("t3", 2'd3, 32'hA5A5_0000, wr0, rd0, 0, 1, 32'h4000_0004);
    slverr_idx = -1; aw_lag = 1'b0;

    // 4: AWREADY never comes
    aw_never = 1'b1;
    start(2'd0, 32'd0);
    c = 0;
    while (!awvalid && c < 50) begin @(negedge clk); c++; end
    chk("t4_awv", awvalid, 1);
    c = 0;
    while (!timeout && c < 3000) begin @(negedge clk); c++; end
    chk("t4_cycles", c, 1024);
    chk("t4_flags", {timeout, error, txn_done, awvalid, busy}, 5'b11100);
    chk("t4_fa", fail_addr, BASE);
    aw_never = 1'b0;
    reset_pulse();

    // 5: walking one and LFSR from a zero seed
    wr0 = nwr; rd0 = nrd;
    start(2'd1, $urandom);
    verify("t5a", 2'd1, 32'd0, wr0, rd0, 0, 0, 0);
    chk("t5a_w32", mem[32], 32'h0000_0001);
    chk("t5a_w39", mem[39], 32'h0000_0080);
    wr0 = nwr; rd0 = nrd;
    start(2'd2, 32'd0);
    verify("t5b", 2'd2, 32'd0, wr0, rd0, 0, 0, 0);
    chk("t5b_w0", mem[0], 32'h0000_0001);

    // randomized runs with stalling slave and random faults
    rnd = 1'b1;
    for (int r = 0; r < 8; r++) begin
      m = 2'($urandom_range(0, 3));
      s = $urandom;
      corrupt_idx = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, N - 1);
      slverr_idx = ($urandom_range(0, 2) != 0) ? -1 : $urandom_range(0, N - 1);
      e_cnt = (corrupt_idx >= 0) ? 1 : 0;
      e_err = (corrupt_idx >= 0) || (slverr_idx >= 0);
      fa = (slverr_idx >= 0) ? BASE + 32'(4 * slverr_idx)
                             : BASE + 32'(4 * corrupt_idx);
      wr0 = nwr; rd0 = nrd;
      start(m, s);
      verify("rnd", m, s, wr0, rd0, e_cnt, e_err, fa);
    end
    corrupt_idx = -1; slverr_idx = -1;

    // 6: reset during the read phase, then a fresh run with a busy re-trigger
    start(2'd0, 32'h77);
    c = 0;
    while (!rready && c < 5000) begin @(negedge clk); c++; end
    chk("t6_rd", rready, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctl", {txn_done, error, timeout, busy, awvalid, wvalid,
                       bready, arvalid, rready}, 0);
    chk("t6_rst_cnt", {err_count, fail_addr}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s = $urandom;
    wr0 = nwr; rd0 = nrd;
    start(2'd3, s);
    repeat (4) @(negedge clk);
    chk("t6_busy", busy, 1);
    init = 1'b1;
    verify("t6", 2'd3, s, wr0, rd0, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("t6_hold", {txn_done, busy}, 2'b10);
    init = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
